seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
//  Parametrised time-multiplexed seven-segment driver for N digits, replacing the fixed 2-digit mux.
//  Captures a packed digit word into a shadow register on a load strobe and scans one digit per refresh tick.
//  Provides hex/decimal glyphs, leading-zero blanking, per-digit DP and output polarity.
//  Sits between game/timer logic and the uo_out pins of the tt_um_* top.
// PARAMETERS
//  NUM_DIGITS   4        digits scanned, >=1
//  REFRESH_DIV  4        clk cycles per digit slot, >=1 (1 = advance every cycle)
//  HEX_EN       0        1: codes 10-15 show A,b,C,d,E,F; 0: codes 10-15 blank
//  BLANK_LZ     0        1: blank leading zero digits; digit 0 is never blanked
//  ACTIVE_LOW   0        1: invert seg, dp and dig_en at the pins
// PORTS
//  clk       in   1             system clock
//  rst_n     in   1             asynchronous reset, active low
//  load      in   1             capture value_in/dp_in into shadow
//  value_in  in   4*NUM_DIGITS  packed BCD/hex; digit i = value_in[4i+3:4i], digit 0 = least significant
//  dp_in     in   NUM_DIGITS    decimal point per digit
//  blank     in   1             force the display dark
//  seg       out  7             {g,f,e,d,c,b,a}, registered
//  dp        out  1             decimal point of the active digit, registered
//  dig_en    out  NUM_DIGITS    one-hot digit enable, registered
//  dig_idx   out  IDXW          active digit index, registered; IDXW = max(1,$clog2(NUM_DIGITS))
//  frame     out  1             1-cycle pulse when the scan wraps from NUM_DIGITS-1 to 0
// BEHAVIOUR
//  Clock: single clk. Reset: rst_n asynchronous and active low.
//  Reset: the refresh counter, scan index, shadow value and shadow dp all clear to 0. seg, dp and
//   dig_en clear to the "off" level (all 0, or all 1 if ACTIVE_LOW). dig_idx=0, frame=0.
//  The refresh counter runs 0..REFRESH_DIV-1 and wraps. tick=1 when the counter is at REFRESH_DIV-1.
//  On tick the scan index advances. It goes from NUM_DIGITS-1 back to 0, and frame pulses on that same edge.
//  NUM_DIGITS=1: the index stays 0; frame pulses on every tick.
//  Load: the shadow takes value_in/dp_in on the clk edge where load=1. The first use of the new shadow
//   is in the outputs one cycle later. A load repeated every cycle is legal; the last one wins.
//  Outputs are registered from (next index, shadow), so the pins lag the internal state by 1 clk.
//   load and tick in the same cycle: the new index and the old shadow make the next outputs;
//   the new shadow shows from the cycle after that.
//  Glyph table (a..g on bits 0..6):
//   0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F; A=77 b=7C C=39 d=5E E=79 F=71.
//  Leading-zero blank (BLANK_LZ=1): digit k is blanked when digits k..NUM_DIGITS-1 are all 0 and k>0.
//   A blanked digit has seg off and dp still follows dp_in. dig_en still strobes for uniform duty.
//  blank=1: seg, dp and dig_en are all off on the next edge. Scanning and loading continue underneath.
//   Releasing blank resumes at the current index with no restart.
//  dig_en is exactly one-hot (before polarity) whenever blank=0. dig_idx equals the index of the asserted bit.
//  rst_n asserted mid-scan: everything returns to reset values at once, with no glitch-free requirement.
//   Scanning restarts from digit 0 and the shadow is empty (shows "0", or "0" plus blanks with BLANK_LZ).
//  Width rules: the counter width is max(1,$clog2(REFRESH_DIV)). Compare to REFRESH_DIV-1 and never rely
//   on natural overflow. The index compares to NUM_DIGITS-1 in the same way.
// STRUCTURE
//  Shared package seg7_pkg holds:
//   - the SEG_* glyph localparams and the blank code;
//   - the function seg7_glyph(code, hex_en) returning 7 bits.
//  Sub-module seg7_decode wraps the pure-combinational glyph lookup (4-bit code, HEX_EN -> 7 bits).
//  The top holds the counter, index, shadow, LZ mask, polarity and output registers.
//  seg7_decode is reused by other display users.
// TESTING  (NUM_DIGITS=4, REFRESH_DIV=4 unless noted)
//  1 Reset then idle 20 clk -> seg=3F in every slot; dig_en 0001,0010,0100,1000 for 4 clk each;
//    frame pulses every 16 clk.
//  2 load value_in=16'h1234, dp_in=4'b0100 -> slots show 4F(3? no:
//    idx0=66 '4', idx1=4F '3', idx2=5B '2' with dp=1, idx3=06 '1'.
//  3 HEX_EN=0, load 16'hABCD -> seg=00 in all slots.
//    HEX_EN=1, same load -> idx0..3 = 5E,39,7C,77.
//  4 BLANK_LZ=1, load 16'h0070 -> idx3 and idx2 have seg=00, idx1=07, idx0=3F.
//    Then load 0 -> only idx0=3F.
//  5 blank=1 for 10 clk mid-scan -> dig_en=0, seg=0 from the next edge.
//    After release, dig_idx continues from the expected count. load during blank is applied.
//  6 load coincident with tick, and rst_n pulsed low for half a cycle mid-slot ->
//    ordering as in BEHAVIOUR; reset values appear asynchronously and the scan restarts at idx0.
//  7 REFRESH_DIV=1, NUM_DIGITS=1, ACTIVE_LOW=1 -> dig_en constantly 0 (active), frame every clk,
//    seg = ~glyph.
```

Correction to TESTING line 2, which is garbled above: the required response is idx0=66 ('4'), idx1=4F ('3'), idx2=5B ('2') with dp=1, idx3=06 ('1').

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared seven-segment glyph set and code-to-segment lookup.
// Bit order is {g,f,e,d,c,b,a}; segment a is bit 0.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Codes 10-15 render as letters only when hex_en is set, otherwise dark.
  function automatic logic [6:0] seg7_glyph(input logic [3:0] code, input logic hex_en);
    logic [6:0] g;
    case (code)
      4'h0:    g = SEG_0;
      4'h1:    g = SEG_1;
      4'h2:    g = SEG_2;
      4'h3:    g = SEG_3;
      4'h4:    g = SEG_4;
      4'h5:    g = SEG_5;
      4'h6:    g = SEG_6;
      4'h7:    g = SEG_7;
      4'h8:    g = SEG_8;
      4'h9:    g = SEG_9;
      4'hA:    g = hex_en ? SEG_A : SEG_BLANK;
      4'hB:    g = hex_en ? SEG_B : SEG_BLANK;
      4'hC:    g = hex_en ? SEG_C : SEG_BLANK;
      4'hD:    g = hex_en ? SEG_D : SEG_BLANK;
      4'hE:    g = hex_en ? SEG_E : SEG_BLANK;
      4'hF:    g = hex_en ? SEG_F : SEG_BLANK;
      default: g = SEG_BLANK;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Pure combinational 4-bit code to seven-segment glyph decoder.
// Shared by every display user so the glyph table lives in one place.
module seg7_decode
  import seg7_pkg::*;
#(
  parameter bit HEX_EN = 1'b0
) (
  input  logic [3:0] i_code,
  output logic [6:0] o_seg
);

  assign o_seg = seg7_glyph(i_code, HEX_EN);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver: shadow capture on load,
// one digit per refresh slot, optional leading-zero blanking and pin polarity.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 4,
  parameter bit HEX_EN      = 1'b0,
  parameter bit BLANK_LZ    = 1'b0,
  parameter bit ACTIVE_LOW  = 1'b0,
  localparam int IDXW       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   dig_en,
  output logic [IDXW-1:0]         dig_idx,
  output logic                    frame
);

  localparam int                    CW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0]         CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IDXW-1:0]       IDX_LAST = IDXW'(NUM_DIGITS - 1);
  localparam logic                  POL      = ACTIVE_LOW;
  localparam logic [6:0]            SEG_OFF  = {7{POL}};
  localparam logic [NUM_DIGITS-1:0] EN_OFF   = {NUM_DIGITS{POL}};

  logic [CW-1:0]           r_cnt;
  logic [CW-1:0]           w_cnt_nxt;
  logic [IDXW-1:0]         r_idx;
  logic [IDXW-1:0]         w_idx_nxt;
  logic                    w_tick;
  logic                    w_wrap;
  logic [4*NUM_DIGITS-1:0] r_val;
  logic [NUM_DIGITS-1:0]   r_dpv;
  logic [NUM_DIGITS-1:0]   w_lz;
  logic                    w_zero_run;
  logic [3:0]              w_code;
  logic                    w_dp_sel;
  logic                    w_lz_sel;
  logic [6:0]              w_glyph;
  logic [NUM_DIGITS-1:0]   w_en_raw;
  logic [6:0]              w_seg_pin;
  logic                    w_dp_pin;
  logic [NUM_DIGITS-1:0]   w_en_pin;
  logic [6:0]              r_seg;
  logic                    r_dp;
  logic [NUM_DIGITS-1:0]   r_en;
  logic                    r_frame;

  // Refresh tick and next scan position; explicit compares avoid relying on wrap-around.
  always_comb begin
    w_tick = (r_cnt == CNT_LAST);
    w_wrap = w_tick && (r_idx == IDX_LAST);
    if (w_tick) begin
      w_cnt_nxt = {CW{1'b0}};
    end else begin
      w_cnt_nxt = r_cnt + CW'(1);
    end
    if (w_wrap) begin
      w_idx_nxt = {IDXW{1'b0}};
    end else if (w_tick) begin
      w_idx_nxt = r_idx + IDXW'(1);
    end else begin
      w_idx_nxt = r_idx;
    end
  end

  // Refresh counter and scan index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= {CW{1'b0}};
      r_idx <= {IDXW{1'b0}};
    end else begin
      r_cnt <= w_cnt_nxt;
      r_idx <= w_idx_nxt;
    end
  end

  // Shadow capture; back-to-back loads simply overwrite.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_val <= {(4*NUM_DIGITS){1'b0}};
      r_dpv <= {NUM_DIGITS{1'b0}};
    end else if (load) begin
      r_val <= value_in;
      r_dpv <= dp_in;
    end
  end

  // Leading-zero mask: a digit blanks when it and everything above it is zero; digit 0 never blanks.
  always_comb begin
    w_zero_run = 1'b1;
    w_lz       = {NUM_DIGITS{1'b0}};
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      w_zero_run = w_zero_run & (r_val[4*k +: 4] == 4'h0);
      w_lz[k]    = BLANK_LZ && w_zero_run && (k != 0);
    end
  end

  // AND-OR select of the digit that the next scan position will show.
  always_comb begin
    w_code   = 4'h0;
    w_dp_sel = 1'b0;
    w_lz_sel = 1'b0;
    w_en_raw = {NUM_DIGITS{1'b0}};
    for (int k = 0; k < NUM_DIGITS; k++) begin
      w_en_raw[k] = (w_idx_nxt == IDXW'(k));
      w_code      = w_code | (r_val[4*k +: 4] & {4{w_en_raw[k]}});
      w_dp_sel    = w_dp_sel | (r_dpv[k] & w_en_raw[k]);
      w_lz_sel    = w_lz_sel | (w_lz[k] & w_en_raw[k]);
    end
  end

  seg7_decode #(
    .HEX_EN (HEX_EN)
  ) u_decode (
    .i_code (w_code),
    .o_seg  (w_glyph)
  );

  // Blank override and pin polarity; XOR with the off pattern inverts for active-low pins.
  always_comb begin
    if (blank) begin
      w_seg_pin = SEG_OFF;
      w_dp_pin  = POL;
      w_en_pin  = EN_OFF;
    end else begin
      w_seg_pin = (w_lz_sel ? SEG_BLANK : w_glyph) ^ SEG_OFF;
      w_dp_pin  = w_dp_sel ^ POL;
      w_en_pin  = w_en_raw ^ EN_OFF;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg   <= SEG_OFF;
      r_dp    <= POL;
      r_en    <= EN_OFF;
      r_frame <= 1'b0;
    end else begin
      r_seg   <= w_seg_pin;
      r_dp    <= w_dp_pin;
      r_en    <= w_en_pin;
      r_frame <= w_wrap;
    end
  end

  assign seg     = r_seg;
  assign dp      = r_dp;
  assign dig_en  = r_en;
  assign dig_idx = r_idx;
  assign frame   = r_frame;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench: stimulus queues cycle-stamped expectations, a negedge monitor
// pops and compares them against four differently parameterised instances.
module tb_seg7_scan_driver;

  typedef struct {
    int         cyc;
    int         dut;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] en;
    logic [1:0] idx;
    logic       frame;
    bit         full;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   nchk = 0;
  int   nfail = 0;
  int   cyc = 0;
  int   e0 = 0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic        blank = 1'b0;
  logic [15:0] value_in = 16'h0000;
  logic [3:0]  dp_in = 4'h0;
  logic [3:0]  s_val = 4'h0;
  logic        s_dp = 1'b0;
  logic        s_blank = 1'b0;

  logic [6:0] a_seg, h_seg, z_seg, s_seg;
  logic       a_dp, h_dp, z_dp, s_dp_o;
  logic [3:0] a_en, h_en, z_en;
  logic [0:0] s_en;
  logic [1:0] a_idx, h_idx, z_idx;
  logic [0:0] s_idx;
  logic       a_fr, h_fr, z_fr, s_fr;

  seg7_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .HEX_EN(1'b0), .BLANK_LZ(1'b0), .ACTIVE_LOW(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .load(load), .value_in(value_in), .dp_in(dp_in), .blank(blank),
    .seg(a_seg), .dp(a_dp), .dig_en(a_en), .dig_idx(a_idx), .frame(a_fr));

  seg7_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .HEX_EN(1'b1), .BLANK_LZ(1'b0), .ACTIVE_LOW(1'b0)) dut_h (
    .clk(clk), .rst_n(rst_n), .load(load), .value_in(value_in), .dp_in(dp_in), .blank(blank),
    .seg(h_seg), .dp(h_dp), .dig_en(h_en), .dig_idx(h_idx), .frame(h_fr));

  seg7_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .HEX_EN(1'b0), .BLANK_LZ(1'b1), .ACTIVE_LOW(1'b0)) dut_z (
    .clk(clk), .rst_n(rst_n), .load(load), .value_in(value_in), .dp_in(dp_in), .blank(blank),
    .seg(z_seg), .dp(z_dp), .dig_en(z_en), .dig_idx(z_idx), .frame(z_fr));

  seg7_scan_driver #(.NUM_DIGITS(1), .REFRESH_DIV(1), .HEX_EN(1'b0), .BLANK_LZ(1'b0), .ACTIVE_LOW(1'b1)) dut_s (
    .clk(clk), .rst_n(rst_n), .load(load), .value_in(s_val), .dp_in(s_dp), .blank(s_blank),
    .seg(s_seg), .dp(s_dp_o), .dig_en(s_en), .dig_idx(s_idx), .frame(s_fr));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached with %0d checks pending", q.size());
    $fatal(1, "watchdog");
  end

  // Scan-position model for the 4-digit, 4-cycle-slot instances, counted from the first edge after reset.
  function automatic int slot_of(int m);
    return ((m - e0) / 4) % 4;
  endfunction

  function automatic logic frame_of(int m);
    return ((m - e0) % 16) == 0;
  endfunction

  task automatic push(int c, int d, logic [6:0] sg, logic p, logic [3:0] en, logic [1:0] ix,
                      logic fr, bit full, string nm);
    exp_t e;
    e.cyc = c; e.dut = d; e.seg = sg; e.dp = p; e.en = en; e.idx = ix; e.frame = fr;
    e.full = full; e.nm = nm;
    q.push_back(e);
  endtask

  // gl packs the four per-slot glyphs as {slot3,slot2,slot1,slot0}.
  task automatic chk_span(int d, int start, int len, int step, logic [27:0] gl, logic [3:0] dpv, string nm);
    int s;
    for (int m = start; m < start + len; m += step) begin
      s = slot_of(m);
      push(m, d, gl[7*s +: 7], dpv[s], 4'(1 << s), 2'(s), frame_of(m), 1'b1, nm);
    end
  endtask

  task automatic chk_off(int d, int start, int len, string nm);
    for (int m = start; m < start + len; m++) begin
      push(m, d, 7'h00, 1'b0, 4'b0000, 2'b00, 1'b0, 1'b0, nm);
    end
  endtask

  task automatic push_reset(int c, string nm);
    push(c, 0, 7'h00, 1'b0, 4'b0000, 2'b00, 1'b0, 1'b1, nm);
    push(c, 1, 7'h00, 1'b0, 4'b0000, 2'b00, 1'b0, 1'b1, nm);
    push(c, 2, 7'h00, 1'b0, 4'b0000, 2'b00, 1'b0, 1'b1, nm);
    push(c, 3, 7'h7F, 1'b1, 4'b0001, 2'b00, 1'b0, 1'b1, nm);
  endtask

  task automatic do_load(logic [15:0] v, logic [3:0] d, output int vis);
    load = 1'b1; value_in = v; dp_in = d;
    @(posedge clk); #1;
    load = 1'b0;
    vis = cyc + 1;
  endtask

  task automatic check(exp_t e);
    logic [6:0] as;
    logic       ad;
    logic [3:0] ae;
    logic [1:0] ai;
    logic       af;
    bit         ok;
    case (e.dut)
      0:       begin as = a_seg; ad = a_dp;   ae = a_en;          ai = a_idx;          af = a_fr; end
      1:       begin as = h_seg; ad = h_dp;   ae = h_en;          ai = h_idx;          af = h_fr; end
      2:       begin as = z_seg; ad = z_dp;   ae = z_en;          ai = z_idx;          af = z_fr; end
      default: begin as = s_seg; ad = s_dp_o; ae = {3'b000, s_en}; ai = {1'b0, s_idx}; af = s_fr; end
    endcase
    nchk++;
    if (e.cyc != cyc) begin
      nfail++;
      $display("FAIL %s: check for cycle %0d never sampled (now %0d)", e.nm, e.cyc, cyc);
    end else begin
      ok = (as === e.seg) && (ad === e.dp) && (ae === e.en);
      if (e.full) ok = ok && (ai === e.idx) && (af === e.frame);
      if (!ok) begin
        nfail++;
        $display("FAIL %s dut%0d cyc%0d: got seg=%h dp=%b en=%b idx=%0d frame=%b, expected seg=%h dp=%b en=%b idx=%0d frame=%b",
                 e.nm, e.dut, cyc, as, ad, ae, ai, af, e.seg, e.dp, e.en, e.idx, e.frame);
      end
    end
  endtask

  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc <= cyc) begin
        check(q[i]);
        q.delete(i);
      end
    end
  end

  initial begin
    int v;
    int c;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    e0 = cyc;

    // reset state, idle scan of an empty shadow, frame cadence
    push_reset(e0, "reset");
    chk_span(0, e0 + 1, 20, 1, {4{7'h3F}}, 4'b0000, "idle_a");
    chk_span(1, e0 + 1, 20, 4, {4{7'h3F}}, 4'b0000, "idle_h");
    chk_span(2, e0 + 1, 20, 4, {7'h00, 7'h00, 7'h00, 7'h3F}, 4'b0000, "idle_lz");
    chk_span(0, e0 + 32, 2, 1, {4{7'h3F}}, 4'b0000, "idle_frame");
    for (int m = e0 + 1; m <= e0 + 6; m++) push(m, 3, 7'h40, 1'b1, 4'b0000, 2'b00, 1'b1, 1'b1, "single_idle");
    repeat (34) @(posedge clk); #1;

    // decimal digits with one decimal point
    do_load(16'h1234, 4'b0100, v);
    chk_span(0, v, 16, 1, {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'b0100, "bcd_a");
    chk_span(1, v, 16, 4, {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'b0100, "bcd_h");
    chk_span(2, v, 16, 4, {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'b0100, "bcd_lz");
    repeat (18) @(posedge clk); #1;

    // hex codes: dark without HEX_EN, letters with it
    do_load(16'hABCD, 4'b0000, v);
    chk_span(0, v, 16, 4, {4{7'h00}}, 4'b0000, "hex_off");
    chk_span(1, v, 16, 4, {7'h77, 7'h7C, 7'h39, 7'h5E}, 4'b0000, "hex_on");
    chk_span(2, v, 16, 4, {4{7'h00}}, 4'b0000, "hex_lz");
    repeat (18) @(posedge clk); #1;

    // leading-zero blanking
    do_load(16'h0070, 4'b0000, v);
    chk_span(2, v, 16, 4, {7'h00, 7'h00, 7'h07, 7'h3F}, 4'b0000, "lz_0070");
    chk_span(0, v, 16, 4, {7'h3F, 7'h3F, 7'h07, 7'h3F}, 4'b0000, "nolz_0070");
    repeat (18) @(posedge clk); #1;
    do_load(16'h0000, 4'b0000, v);
    chk_span(2, v, 16, 4, {7'h00, 7'h00, 7'h00, 7'h3F}, 4'b0000, "lz_zero");
    chk_span(0, v, 16, 4, {4{7'h3F}}, 4'b0000, "nolz_zero");
    repeat (18) @(posedge clk); #1;

    // blank for 10 cycles with a load underneath
    c = cyc;
    blank = 1'b1;
    chk_off(0, c + 1, 10, "blank_a");
    chk_off(2, c + 1, 10, "blank_lz");
    repeat (3) @(posedge clk); #1;
    load = 1'b1; value_in = 16'h5678; dp_in = 4'b1111;
    @(posedge clk); #1;
    load = 1'b0;
    repeat (6) @(posedge clk); #1;
    blank = 1'b0;
    chk_span(0, c + 11, 16, 1, {7'h6D, 7'h7D, 7'h07, 7'h7F}, 4'b1111, "unblank_a");
    chk_span(2, c + 11, 16, 4, {7'h6D, 7'h7D, 7'h07, 7'h7F}, 4'b1111, "unblank_lz");
    repeat (18) @(posedge clk); #1;

    // load on a tick edge: new index with old shadow first, new shadow one cycle later
    while (((cyc + 1 - e0) % 4) != 0) begin
      @(posedge clk); #1;
    end
    c = cyc + 1;
    do_load(16'h1111, 4'b0000, v);
    chk_span(0, c, 1, 1, {7'h6D, 7'h7D, 7'h07, 7'h7F}, 4'b1111, "tick_load_old");
    chk_span(0, c + 1, 3, 1, {4{7'h06}}, 4'b0000, "tick_load_new");
    repeat (4) @(posedge clk); #1;

    // half-cycle asynchronous reset in the middle of a slot
    while (((cyc - e0) % 4) != 2) begin
      @(posedge clk); #1;
    end
    #1 rst_n = 1'b0;
    push_reset(cyc, "async_reset");
    #5 rst_n = 1'b1;
    e0 = cyc;
    chk_span(0, e0 + 1, 8, 1, {4{7'h3F}}, 4'b0000, "restart_a");
    chk_span(2, e0 + 1, 8, 4, {7'h00, 7'h00, 7'h00, 7'h3F}, 4'b0000, "restart_lz");
    chk_span(0, e0 + 16, 1, 1, {4{7'h3F}}, 4'b0000, "restart_frame");
    repeat (18) @(posedge clk); #1;

    // single digit, divide-by-1, active-low pins
    s_val = 4'h5; s_dp = 1'b1;
    push(cyc + 1, 3, 7'h40, 1'b1, 4'b0000, 2'b00, 1'b1, 1'b1, "single_old");
    do_load(16'h0000, 4'b0000, v);
    for (int m = v; m < v + 6; m++) push(m, 3, 7'h12, 1'b0, 4'b0000, 2'b00, 1'b1, 1'b1, "single_load");

    for (int i = 0; i < 200; i++) begin
      if (q.size() == 0) break;
      @(posedge clk);
    end
    @(posedge clk); #1;
    if (q.size() != 0) begin
      nchk++;
      nfail++;
      $display("FAIL drain: %0d checks never reached", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
